// File: rtl/sys_ctrl_pkg.sv
// Shared state encoding and command constants for the second-generation system controller.
package sys_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        RF_WR,
        RF_RD,
        GET_A,
        GET_B,
        GET_FUN,
        ALU_WAIT,
        TX
    } state_e;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

endpackage

// File: rtl/sys_ctrl_gen2_if.sv
// Bus bundle between the system controller and its UART RX, register file, ALU and TX FIFO.
interface sys_ctrl_gen2_if #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned ALU_OUT_BYTES = 2
);

    logic [DATA_WIDTH-1:0]               RX_p_data;
    logic                                RX_d_valid;
    logic [DATA_WIDTH-1:0]               Rd_data;
    logic                                RdData_valid;
    logic [DATA_WIDTH*ALU_OUT_BYTES-1:0] ALU_OUT;
    logic                                OUT_VALID;
    logic                                FIFO_full;

    logic                                ALU_EN;
    logic [3:0]                          ALU_FUN;
    logic                                CLK_EN;
    logic [ADDR_WIDTH-1:0]               Address;
    logic                                WrEN;
    logic                                RdEN;
    logic [DATA_WIDTH-1:0]               WrData;
    logic [DATA_WIDTH-1:0]               TX_p_data;
    logic                                TX_d_valid;
    logic                                busy;
    logic                                timeout_err;

    modport master (
        input  RX_p_data, RX_d_valid, Rd_data, RdData_valid, ALU_OUT, OUT_VALID, FIFO_full,
        output ALU_EN, ALU_FUN, CLK_EN, Address, WrEN, RdEN, WrData,
               TX_p_data, TX_d_valid, busy, timeout_err
    );

    modport slave (
        output RX_p_data, RX_d_valid, Rd_data, RdData_valid, ALU_OUT, OUT_VALID, FIFO_full,
        input  ALU_EN, ALU_FUN, CLK_EN, Address, WrEN, RdEN, WrData,
               TX_p_data, TX_d_valid, busy, timeout_err
    );

endinterface

// File: rtl/ctrl_tx_serializer.sv
// Shifts out up to MAX_BYTES bytes, LSB first, under a valid/full handshake toward the TX FIFO.
module ctrl_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BYTES  = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_i,
    input  logic [DATA_WIDTH*MAX_BYTES-1:0]   data_i,
    input  logic [$clog2(MAX_BYTES+1)-1:0]    count_i,
    input  logic                              fifo_full_i,
    output logic [DATA_WIDTH-1:0]             tx_data_o,
    output logic                              tx_valid_o,
    output logic                              done_c_o
);

    localparam int unsigned SH_W  = DATA_WIDTH * MAX_BYTES;
    localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);

    logic [SH_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0] left_q, left_d;
    logic             valid_q, valid_d;
    logic             pop_c;

    // A byte leaves on any cycle it is presented and the FIFO has room.
    always_comb begin
        shift_d = shift_q;
        left_d  = left_q;
        valid_d = valid_q;
        pop_c   = valid_q && !fifo_full_i;
        if (load_i) begin
            shift_d = data_i;
            left_d  = count_i;
            valid_d = (count_i != '0);
        end else if (pop_c) begin
            shift_d = shift_q >> DATA_WIDTH;
            left_d  = left_q - CNT_W'(1);
            valid_d = (left_q != CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            left_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            left_q  <= left_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data_o  = shift_q[DATA_WIDTH-1:0];
    assign tx_valid_o = valid_q;
    assign done_c_o   = pop_c && (left_q == CNT_W'(1));

endmodule

// File: rtl/sys_ctrl_gen2.sv
// Command-frame decoder: drives register-file and ALU operations and returns results over TX.
module sys_ctrl_gen2
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned ALU_OUT_BYTES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter logic [7:0]  ERR_CODE       = 8'hEE
) (
    input  logic            CLK,
    input  logic            RST,
    sys_ctrl_gen2_if.master bus
);

    localparam int unsigned RES_W = DATA_WIDTH * ALU_OUT_BYTES;
    localparam int unsigned CNT_W = $clog2(ALU_OUT_BYTES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e                state_q, state_d;
    logic                  is_rd_q, is_rd_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  alu_en_q, alu_en_d;
    logic                  clk_en_q, clk_en_d;
    logic [3:0]            alu_fun_q, alu_fun_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  timeout_q, timeout_d;
    logic                  busy_q, busy_d;

    logic                  ser_load_c;
    logic [RES_W-1:0]      ser_data_c;
    logic [CNT_W-1:0]      ser_cnt_c;
    logic                  ser_done_c;
    logic                  in_get_c;
    logic                  rx_v_c;
    logic [DATA_WIDTH-1:0] rx_byte_c;

    assign rx_v_c    = bus.RX_d_valid;
    assign rx_byte_c = bus.RX_p_data;
    assign in_get_c  = state_q inside {GET_ADDR, GET_DATA, GET_A, GET_B, GET_FUN};

    // Next-state and registered-output logic; strobes default low every cycle.
    always_comb begin
        state_d    = state_q;
        is_rd_d    = is_rd_q;
        tmo_d      = '0;
        alu_en_d   = alu_en_q;
        clk_en_d   = clk_en_q;
        alu_fun_d  = alu_fun_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        timeout_d  = 1'b0;
        ser_load_c = 1'b0;
        ser_data_c = '0;
        ser_cnt_c  = '0;

        case (state_q)
            IDLE: begin
                if (rx_v_c) begin
                    case (rx_byte_c)
                        DATA_WIDTH'(CMD_WR): begin
                            is_rd_d = 1'b0;
                            state_d = GET_ADDR;
                        end
                        DATA_WIDTH'(CMD_RD): begin
                            is_rd_d = 1'b1;
                            state_d = GET_ADDR;
                        end
                        DATA_WIDTH'(CMD_ALU_OP):  state_d = GET_A;
                        DATA_WIDTH'(CMD_ALU_NOP): state_d = GET_FUN;
                        default: begin
                            ser_load_c = 1'b1;
                            ser_data_c = RES_W'(DATA_WIDTH'(ERR_CODE));
                            ser_cnt_c  = CNT_W'(1);
                            state_d    = TX;
                        end
                    endcase
                end
            end
            GET_ADDR: begin
                if (rx_v_c) begin
                    addr_d = rx_byte_c[ADDR_WIDTH-1:0];
                    if (is_rd_q) begin
                        rd_en_d = 1'b1;
                        state_d = RF_RD;
                    end else begin
                        state_d = GET_DATA;
                    end
                end
            end
            GET_DATA: begin
                if (rx_v_c) begin
                    wr_data_d = rx_byte_c;
                    wr_en_d   = 1'b1;
                    state_d   = RF_WR;
                end
            end
            RF_WR: begin
                ser_load_c = 1'b1;
                ser_data_c = RES_W'(wr_data_q);
                ser_cnt_c  = CNT_W'(1);
                state_d    = TX;
            end
            RF_RD: begin
                if (bus.RdData_valid) begin
                    ser_load_c = 1'b1;
                    ser_data_c = RES_W'(bus.Rd_data);
                    ser_cnt_c  = CNT_W'(1);
                    state_d    = TX;
                end
            end
            GET_A: begin
                if (rx_v_c) begin
                    addr_d    = ADDR_WIDTH'(OPA_ADDR);
                    wr_data_d = rx_byte_c;
                    wr_en_d   = 1'b1;
                    state_d   = GET_B;
                end
            end
            GET_B: begin
                if (rx_v_c) begin
                    addr_d    = ADDR_WIDTH'(OPB_ADDR);
                    wr_data_d = rx_byte_c;
                    wr_en_d   = 1'b1;
                    state_d   = GET_FUN;
                end
            end
            GET_FUN: begin
                if (rx_v_c) begin
                    alu_fun_d = rx_byte_c[3:0];
                    alu_en_d  = 1'b1;
                    clk_en_d  = 1'b1;
                    state_d   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (bus.OUT_VALID) begin
                    alu_en_d   = 1'b0;
                    clk_en_d   = 1'b0;
                    ser_load_c = 1'b1;
                    ser_data_c = bus.ALU_OUT;
                    ser_cnt_c  = CNT_W'(ALU_OUT_BYTES);
                    state_d    = TX;
                end
            end
            TX: begin
                if (ser_done_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Inter-byte watchdog; an arriving byte always beats the expiry.
        if (in_get_c && !rx_v_c) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_d = 1'b1;
                state_d   = IDLE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            is_rd_q   <= 1'b0;
            tmo_q     <= '0;
            alu_en_q  <= 1'b0;
            clk_en_q  <= 1'b0;
            alu_fun_q <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_data_q <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_rd_q   <= is_rd_d;
            tmo_q     <= tmo_d;
            alu_en_q  <= alu_en_d;
            clk_en_q  <= clk_en_d;
            alu_fun_q <= alu_fun_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            wr_data_q <= wr_data_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    ctrl_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BYTES  (ALU_OUT_BYTES)
    ) u_tx_ser (
        .clk         (CLK),
        .rst         (RST),
        .load_i      (ser_load_c),
        .data_i      (ser_data_c),
        .count_i     (ser_cnt_c),
        .fifo_full_i (bus.FIFO_full),
        .tx_data_o   (bus.TX_p_data),
        .tx_valid_o  (bus.TX_d_valid),
        .done_c_o    (ser_done_c)
    );

    assign bus.ALU_EN      = alu_en_q;
    assign bus.CLK_EN      = clk_en_q;
    assign bus.ALU_FUN     = alu_fun_q;
    assign bus.Address     = addr_q;
    assign bus.WrEN        = wr_en_q;
    assign bus.RdEN        = rd_en_q;
    assign bus.WrData      = wr_data_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_sys_ctrl_gen2.sv
// Directed self-checking bench for sys_ctrl_gen2 with a 16-cycle frame timeout.
module tb_sys_ctrl_gen2;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    int   wr_pulses = 0;
    int   rd_pulses = 0;
    int   tmo_pulses = 0;
    logic [7:0] txq[$];

    always #5 clk = ~clk;

    sys_ctrl_gen2_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_BYTES(2)) bus ();

    sys_ctrl_gen2 #(
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (4),
        .ALU_OUT_BYTES  (2),
        .TIMEOUT_CYCLES (16),
        .ERR_CODE       (8'hEE)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Strobe counters and a log of every byte the FIFO accepts.
    always @(negedge clk) begin
        if (bus.WrEN) wr_pulses++;
        if (bus.RdEN) rd_pulses++;
        if (bus.timeout_err) tmo_pulses++;
        if (bus.TX_d_valid && !bus.FIFO_full) txq.push_back(bus.TX_p_data);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.RX_p_data  = b;
        bus.RX_d_valid = 1'b1;
        cyc();
        bus.RX_d_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        n_chk++;
        if ({bus.ALU_EN, bus.ALU_FUN, bus.CLK_EN, bus.Address, bus.WrEN, bus.RdEN, bus.WrData,
             bus.TX_p_data, bus.TX_d_valid, bus.busy, bus.timeout_err} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got fun=%h addr=%h wd=%h tx=%h busy=%b want all zero",
                     bus.ALU_FUN, bus.Address, bus.WrData, bus.TX_p_data, bus.busy);
        end
        rst = 1'b0;
        cyc();
        n_chk++;
        if ({bus.busy, bus.TX_d_valid, bus.WrEN} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release: got busy/txv/wren=%b want 000", {bus.busy, bus.TX_d_valid, bus.WrEN});
        end
    endtask

    task automatic test_write();
        int w0;
        w0 = wr_pulses;
        send(8'hAA);
        n_chk++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_busy: got %b want 1", bus.busy);
        end
        send(8'h05);
        send(8'h3C);
        n_chk++;
        if ({bus.WrEN, bus.Address, bus.WrData} !== {1'b1, 4'h5, 8'h3C}) begin
            n_fail++;
            $display("FAIL wr_strobe: got wren=%b addr=%h wd=%h want 1 5 3c", bus.WrEN, bus.Address, bus.WrData);
        end
        cyc();
        n_chk++;
        if ({bus.WrEN, bus.TX_d_valid, bus.TX_p_data} !== {1'b0, 1'b1, 8'h3C}) begin
            n_fail++;
            $display("FAIL wr_echo: got wren=%b txv=%b tx=%h want 0 1 3c", bus.WrEN, bus.TX_d_valid, bus.TX_p_data);
        end
        cyc();
        n_chk++;
        if ({bus.TX_d_valid, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL wr_done: got txv/busy=%b want 00", {bus.TX_d_valid, bus.busy});
        end
        n_chk++;
        if (wr_pulses - w0 !== 1) begin
            n_fail++;
            $display("FAIL wr_pulse_count: got %0d want 1", wr_pulses - w0);
        end
    endtask

    task automatic test_read();
        int r0;
        r0 = rd_pulses;
        send(8'hBB);
        send(8'h07);
        n_chk++;
        if ({bus.RdEN, bus.Address, bus.busy} !== {1'b1, 4'h7, 1'b1}) begin
            n_fail++;
            $display("FAIL rd_strobe: got rden=%b addr=%h busy=%b want 1 7 1", bus.RdEN, bus.Address, bus.busy);
        end
        repeat (3) cyc();
        n_chk++;
        if ({bus.RdEN, bus.TX_d_valid, bus.busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL rd_wait: got rden/txv/busy=%b want 001", {bus.RdEN, bus.TX_d_valid, bus.busy});
        end
        bus.Rd_data      = 8'h5A;
        bus.RdData_valid = 1'b1;
        cyc();
        bus.RdData_valid = 1'b0;
        n_chk++;
        if ({bus.TX_d_valid, bus.TX_p_data} !== {1'b1, 8'h5A}) begin
            n_fail++;
            $display("FAIL rd_tx: got txv=%b tx=%h want 1 5a", bus.TX_d_valid, bus.TX_p_data);
        end
        cyc();
        n_chk++;
        if ({bus.TX_d_valid, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_done: got txv/busy=%b want 00", {bus.TX_d_valid, bus.busy});
        end
        n_chk++;
        if (rd_pulses - r0 !== 1) begin
            n_fail++;
            $display("FAIL rd_pulse_count: got %0d want 1", rd_pulses - r0);
        end
    endtask

    task automatic test_unknown();
        send(8'h7F);
        n_chk++;
        if ({bus.TX_d_valid, bus.TX_p_data, bus.busy} !== {1'b1, 8'hEE, 1'b1}) begin
            n_fail++;
            $display("FAIL err_tx: got txv=%b tx=%h busy=%b want 1 ee 1", bus.TX_d_valid, bus.TX_p_data, bus.busy);
        end
        cyc();
        n_chk++;
        if ({bus.TX_d_valid, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL err_done: got txv/busy=%b want 00", {bus.TX_d_valid, bus.busy});
        end
    endtask

    task automatic test_fifo_full();
        int base;
        int bad;
        base = txq.size();
        bad  = 0;
        send(8'hDD);
        send(8'h02);
        n_chk++;
        if ({bus.ALU_EN, bus.CLK_EN, bus.ALU_FUN} !== {1'b1, 1'b1, 4'h2}) begin
            n_fail++;
            $display("FAIL nop_fun: got en=%b cken=%b fun=%h want 1 1 2", bus.ALU_EN, bus.CLK_EN, bus.ALU_FUN);
        end
        bus.ALU_OUT   = 16'hA55A;
        bus.OUT_VALID = 1'b1;
        bus.FIFO_full = 1'b1;
        cyc();
        bus.OUT_VALID = 1'b0;
        n_chk++;
        if ({bus.ALU_EN, bus.CLK_EN} !== 2'b00) begin
            n_fail++;
            $display("FAIL nop_alu_off: got en/cken=%b want 00", {bus.ALU_EN, bus.CLK_EN});
        end
        for (int i = 0; i < 5; i++) begin
            if (!(bus.TX_d_valid === 1'b1 && bus.TX_p_data === 8'h5A)) bad++;
            if (i == 4) bus.FIFO_full = 1'b0;
            cyc();
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL full_hold: got %0d unstable cycles want 0", bad);
        end
        n_chk++;
        if ({bus.TX_d_valid, bus.TX_p_data} !== {1'b1, 8'hA5}) begin
            n_fail++;
            $display("FAIL full_second: got txv=%b tx=%h want 1 a5", bus.TX_d_valid, bus.TX_p_data);
        end
        cyc();
        n_chk++;
        if ({bus.TX_d_valid, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL full_done: got txv/busy=%b want 00", {bus.TX_d_valid, bus.busy});
        end
        n_chk++;
        if (txq.size() - base !== 2 || txq[base] !== 8'h5A || txq[base+1] !== 8'hA5) begin
            n_fail++;
            $display("FAIL full_stream: got %0d bytes want 2 (5a a5)", txq.size() - base);
        end
    endtask

    task automatic test_alu();
        int w0;
        w0 = wr_pulses;
        send(8'hCC);
        send(8'h12);
        n_chk++;
        if ({bus.WrEN, bus.Address, bus.WrData} !== {1'b1, 4'h0, 8'h12}) begin
            n_fail++;
            $display("FAIL opa_write: got wren=%b addr=%h wd=%h want 1 0 12", bus.WrEN, bus.Address, bus.WrData);
        end
        send(8'h34);
        n_chk++;
        if ({bus.WrEN, bus.Address, bus.WrData} !== {1'b1, 4'h1, 8'h34}) begin
            n_fail++;
            $display("FAIL opb_write: got wren=%b addr=%h wd=%h want 1 1 34", bus.WrEN, bus.Address, bus.WrData);
        end
        send(8'h00);
        n_chk++;
        if ({bus.ALU_EN, bus.CLK_EN, bus.ALU_FUN, bus.WrEN} !== {1'b1, 1'b1, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL alu_start: got en=%b cken=%b fun=%h wren=%b want 1 1 0 0",
                     bus.ALU_EN, bus.CLK_EN, bus.ALU_FUN, bus.WrEN);
        end
        bus.RX_p_data  = 8'hAA;
        bus.RX_d_valid = 1'b1;
        cyc();
        bus.RX_d_valid = 1'b0;
        cyc();
        n_chk++;
        if ({bus.ALU_EN, bus.busy, bus.WrEN, bus.TX_d_valid} !== 4'b1100) begin
            n_fail++;
            $display("FAIL alu_drop_rx: got en/busy/wren/txv=%b want 1100",
                     {bus.ALU_EN, bus.busy, bus.WrEN, bus.TX_d_valid});
        end
        bus.ALU_OUT   = 16'h0046;
        bus.OUT_VALID = 1'b1;
        cyc();
        bus.OUT_VALID = 1'b0;
        n_chk++;
        if ({bus.ALU_EN, bus.CLK_EN, bus.TX_d_valid, bus.TX_p_data} !== {1'b0, 1'b0, 1'b1, 8'h46}) begin
            n_fail++;
            $display("FAIL alu_lsb: got en=%b cken=%b txv=%b tx=%h want 0 0 1 46",
                     bus.ALU_EN, bus.CLK_EN, bus.TX_d_valid, bus.TX_p_data);
        end
        cyc();
        n_chk++;
        if ({bus.TX_d_valid, bus.TX_p_data} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL alu_msb: got txv=%b tx=%h want 1 00", bus.TX_d_valid, bus.TX_p_data);
        end
        cyc();
        n_chk++;
        if ({bus.TX_d_valid, bus.busy} !== 2'b00 || wr_pulses - w0 !== 2) begin
            n_fail++;
            $display("FAIL alu_done: got txv/busy=%b writes=%0d want 00 2",
                     {bus.TX_d_valid, bus.busy}, wr_pulses - w0);
        end
    endtask

    task automatic test_timeout();
        int w0;
        int t0;
        int early;
        w0    = wr_pulses;
        t0    = tmo_pulses;
        early = 0;
        send(8'hAA);
        send(8'h05);
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) early++;
        end
        n_chk++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL tmo_early: got %0d premature cycles want 0", early);
        end
        cyc();
        n_chk++;
        if ({bus.timeout_err, bus.busy, bus.TX_d_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL tmo_fire: got err/busy/txv=%b want 100", {bus.timeout_err, bus.busy, bus.TX_d_valid});
        end
        cyc();
        n_chk++;
        if (bus.timeout_err !== 1'b0 || tmo_pulses - t0 !== 1 || wr_pulses !== w0) begin
            n_fail++;
            $display("FAIL tmo_pulse: got err=%b pulses=%0d writes=%0d want 0 1 0",
                     bus.timeout_err, tmo_pulses - t0, wr_pulses - w0);
        end
        // Bytes landing on the expiry cycle must keep the frame alive.
        send(8'hAA);
        repeat (15) cyc();
        send(8'h05);
        n_chk++;
        if ({bus.timeout_err, bus.busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL tmo_byte_wins: got err/busy=%b want 01", {bus.timeout_err, bus.busy});
        end
        repeat (15) cyc();
        send(8'h3C);
        n_chk++;
        if ({bus.timeout_err, bus.WrEN, bus.Address, bus.WrData} !== {1'b0, 1'b1, 4'h5, 8'h3C}) begin
            n_fail++;
            $display("FAIL tmo_edge_write: got err=%b wren=%b addr=%h wd=%h want 0 1 5 3c",
                     bus.timeout_err, bus.WrEN, bus.Address, bus.WrData);
        end
        cyc();
        cyc();
        n_chk++;
        if ({bus.TX_d_valid, bus.busy} !== 2'b00 || tmo_pulses - t0 !== 1) begin
            n_fail++;
            $display("FAIL tmo_edge_done: got txv/busy=%b pulses=%0d want 00 1",
                     {bus.TX_d_valid, bus.busy}, tmo_pulses - t0);
        end
    endtask

    task automatic test_reset_midframe();
        send(8'hDD);
        send(8'h01);
        bus.ALU_OUT   = 16'h1234;
        bus.OUT_VALID = 1'b1;
        bus.FIFO_full = 1'b1;
        cyc();
        bus.OUT_VALID = 1'b0;
        n_chk++;
        if ({bus.TX_d_valid, bus.TX_p_data, bus.ALU_FUN} !== {1'b1, 8'h34, 4'h1}) begin
            n_fail++;
            $display("FAIL rst_pending: got txv=%b tx=%h fun=%h want 1 34 1", bus.TX_d_valid, bus.TX_p_data, bus.ALU_FUN);
        end
        rst = 1'b1;
        cyc();
        n_chk++;
        if ({bus.ALU_EN, bus.ALU_FUN, bus.CLK_EN, bus.Address, bus.WrEN, bus.RdEN, bus.WrData,
             bus.TX_p_data, bus.TX_d_valid, bus.busy, bus.timeout_err} !== 31'd0) begin
            n_fail++;
            $display("FAIL rst_tx_flush: got fun=%h tx=%h txv=%b busy=%b want all zero",
                     bus.ALU_FUN, bus.TX_p_data, bus.TX_d_valid, bus.busy);
        end
        rst = 1'b0;
        bus.FIFO_full = 1'b0;
        cyc();
        n_chk++;
        if ({bus.TX_d_valid, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_tx_gone: got txv/busy=%b want 00", {bus.TX_d_valid, bus.busy});
        end
        send(8'hCC);
        send(8'h12);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_chk++;
        if ({bus.WrEN, bus.Address, bus.WrData, bus.busy} !== 14'd0) begin
            n_fail++;
            $display("FAIL rst_midframe: got wren=%b addr=%h wd=%h busy=%b want 0 0 00 0",
                     bus.WrEN, bus.Address, bus.WrData, bus.busy);
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.RX_p_data    = '0;
        bus.RX_d_valid   = 1'b0;
        bus.Rd_data      = '0;
        bus.RdData_valid = 1'b0;
        bus.ALU_OUT      = '0;
        bus.OUT_VALID    = 1'b0;
        bus.FIFO_full    = 1'b0;

        test_reset();
        test_write();
        test_read();
        test_unknown();
        test_fifo_full();
        test_alu();
        test_timeout();
        test_reset_midframe();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
